aes_output_monitor: RTL and testbench
=====================================

AES_OUTPUT_MONITOR -- requirements
Module: aes_output_monitor

Interface
REQ-001 Parameter LATENCY, default 21: cycles from input launch to valid out on aes_128.
REQ-002 Parameter WIDTH, default 128: ciphertext width.
REQ-003 Parameter CNT_W, default 32: width of the vector counter and target.
REQ-004 Parameter SIG_SEED, default 128'h0: signature value after reset or clear.
REQ-005 clk  input  1: single clock, same clock that drives aes_128; all state changes on its rising edge.
REQ-006 rst  input  1: reset, asynchronous and active-high.
REQ-007 clear  input  1: synchronous clear of all monitor state.
REQ-008 in_valid  input  1: a state/key pair is presented to aes_128 this cycle.
REQ-009 out  input  WIDTH: aes_128 ciphertext output.
REQ-010 target_count  input  CNT_W: number of encryptions to capture; 0 = unbounded.
REQ-011 out_valid  output  1: out_data holds a valid ciphertext this cycle.
REQ-012 out_data  output  WIDTH: registered captured ciphertext.
REQ-013 vec_count  output  CNT_W: ciphertexts captured so far.
REQ-014 signature  output  WIDTH: MISR compression of all captured ciphertexts.
REQ-015 done  output  1: sticky; target_count ciphertexts captured.
REQ-016 extra_err  output  1: sticky; valid ciphertext arrived after done.

Function
REQ-017 Valid pipeline: LATENCY-bit shift register pipe; each cycle pipe[0] <= in_valid, pipe[k] <= pipe[k-1].
REQ-018 match = pipe[LATENCY-1]; match high means the current out corresponds to in_valid sampled LATENCY cycles earlier.
REQ-019 Capture: on each edge with match high and done low, out_data <= out, out_valid <= 1; otherwise out_valid <= 0 and out_data holds its value.
REQ-020 Total latency: in_valid high at edge N produces out_valid high for the cycle following edge N+LATENCY.
REQ-021 Back-to-back in_valid on consecutive cycles yields out_valid on consecutive cycles with no gaps or drops.
REQ-022 MISR update on capture: signature <= ({signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? 128'h87 : 0)) ^ out (polynomial x^128+x^7+x^2+x+1).
REQ-023 vec_count increments by 1 on each capture and saturates at all-ones; it does not wrap.
REQ-024 done sets on the edge where a capture makes vec_count equal to target_count (target_count != 0); it is visible the same cycle as that final out_valid.
REQ-025 With target_count = 0, done never sets and captures continue indefinitely.
REQ-026 While done is high: no capture, signature and vec_count frozen; match high sets extra_err.
REQ-027 target_count is sampled continuously; lowering it below vec_count does not set done retroactively. Only the equality event at capture sets done.
REQ-028 clear high: pipe, out_valid, out_data, vec_count, done and extra_err are zeroed, and signature is set to SIG_SEED, at the edge. clear beats a simultaneous match or in_valid; that in_valid is discarded.
REQ-029 Pipe contents in flight when done sets are drained without effect except extra_err.

Reset
REQ-030 rst high asynchronously forces pipe = 0, out_valid = 0, out_data = 0, vec_count = 0, signature = SIG_SEED, done = 0 and extra_err = 0.
REQ-031 Reset mid-operation discards all in-flight valids. The first capture after release requires a fresh in_valid and occurs LATENCY+1 cycles later.
REQ-032 rst takes precedence over clear.

Verification
REQ-033 LATENCY=21, SIG_SEED=0, single in_valid pulse at edge 0, out=128'h1 at edge 21 -> out_valid high one cycle after edge 21 only, out_data=1, signature=1, vec_count=1.
REQ-034 Two consecutive in_valid, both outs=128'h1 -> out_valid high 2 consecutive cycles, signature=128'h3, vec_count=2.
REQ-035 target_count=3, 5 consecutive in_valid -> done sets with the 3rd out_valid; vec_count stays 3 and signature stays frozen; extra_err=1 after the 4th match.
REQ-036 Signature seed/wrap: SIG_SEED=128'h8000...0, one capture with out=0 -> signature=128'h87.
REQ-037 rst pulse 10 cycles after a 5-vector burst launch -> no out_valid ever appears for that burst; all outputs read their reset values.
REQ-038 clear asserted in the same cycle as a match -> no capture; vec_count=0; signature=SIG_SEED.

Source files
------------

// File: rtl/aes_output_monitor.sv
// aes_output_monitor: captures aes_128 ciphertexts that line up with earlier
// in_valid launches, counts them and folds them into a MISR signature.
//
// Handshake: out_valid is a single-cycle qualifier for out_data. There is no
// ready/backpressure; a consumer must take out_data in the cycle out_valid is
// high. in_valid likewise has no ready: every launch is tracked.
module aes_output_monitor #(
  parameter int                 LATENCY  = 21,
  parameter int                 WIDTH    = 128,
  parameter int                 CNT_W    = 32,
  parameter logic [WIDTH-1:0]   SIG_SEED = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] out,
  input  logic [CNT_W-1:0] target_count,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] vec_count,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             extra_err
);

  // Feedback taps for x^128 + x^7 + x^2 + x + 1.
  localparam logic [WIDTH-1:0] POLY    = WIDTH'(8'h87);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LATENCY-1:0] pipe;
  logic [LATENCY-1:0] pipe_next;
  logic               match;
  logic               capture;
  logic [CNT_W-1:0]   next_count;
  logic [WIDTH-1:0]   next_sig;
  logic               hit_target;

  // Next-state terms shared by the register blocks below.
  always_comb begin
    pipe_next    = pipe << 1;
    pipe_next[0] = in_valid;
    match        = pipe[LATENCY-1];
    capture      = match && !done;
    next_count   = (vec_count == CNT_MAX) ? vec_count : vec_count + CNT_W'(1);
    next_sig     = {signature[WIDTH-2:0], 1'b0}
                 ^ (signature[WIDTH-1] ? POLY : '0)
                 ^ out;
    // Only the equality reached by a capture sets done; a target lowered
    // below an already-larger count never matches.
    hit_target   = (target_count != '0) && (next_count == target_count);
  end

  // Valid delay line mirroring the aes_128 pipeline depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else if (clear) begin
      pipe <= '0;
    end else begin
      pipe <= pipe_next;
    end
  end

  // Output register: load the ciphertext on capture, otherwise hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= capture;
      if (capture) begin
        out_data <= out;
      end
    end
  end

  // Saturating vector counter and MISR signature, frozen once done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_count <= '0;
      signature <= SIG_SEED;
    end else if (clear) begin
      vec_count <= '0;
      signature <= SIG_SEED;
    end else if (capture) begin
      vec_count <= next_count;
      signature <= next_sig;
    end
  end

  // Sticky status: done on reaching the target, extra_err on late arrivals.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      extra_err <= 1'b0;
    end else if (clear) begin
      done      <= 1'b0;
      extra_err <= 1'b0;
    end else begin
      if (capture && hit_target) begin
        done <= 1'b1;
      end
      if (match && done) begin
        extra_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_output_monitor.sv
// Bench for aes_output_monitor: a default instance plus a second instance
// with a top-bit MISR seed and a 2-bit counter, both checked every cycle
// against a launch-queue model.
module tb_aes_output_monitor;

  localparam int L = 21;
  localparam logic [127:0] SEED_B = {1'b1, 127'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic [127:0] out_bus = '0;
  logic [31:0]  tgt = '0;

  logic         a_valid, b_valid;
  logic [127:0] a_data, b_data, a_sig, b_sig;
  logic [31:0]  a_cnt;
  logic [1:0]   b_cnt;
  logic         a_done, b_done, a_err, b_err;

  aes_output_monitor #(.LATENCY(L), .WIDTH(128), .CNT_W(32), .SIG_SEED(128'h0)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .out(out_bus),
    .target_count(tgt), .out_valid(a_valid), .out_data(a_data),
    .vec_count(a_cnt), .signature(a_sig), .done(a_done), .extra_err(a_err)
  );

  aes_output_monitor #(.LATENCY(L), .WIDTH(128), .CNT_W(2), .SIG_SEED(SEED_B)) u_b (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .out(out_bus),
    .target_count(tgt[1:0]), .out_valid(b_valid), .out_data(b_data),
    .vec_count(b_cnt), .signature(b_sig), .done(b_done), .extra_err(b_err)
  );

  // ---------------- model ----------------
  // exp_q holds the edge number at which each outstanding launch must appear.
  logic [31:0]     exp_q[$];
  int unsigned     edge_n = 0;
  bit              m_valid[2];
  logic [127:0]    m_data[2];
  logic [127:0]    m_sig[2];
  longint unsigned m_cnt[2];
  bit              m_done[2];
  bit              m_err[2];
  longint unsigned max_cnt[2] = '{64'hFFFF_FFFF, 64'd3};
  logic [127:0]    seed[2] = '{128'h0, SEED_B};

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Multiply-by-x in GF(2^128) then add the new word.
  function automatic logic [127:0] misr(input logic [127:0] s, input logic [127:0] d);
    logic [127:0] t;
    t = s << 1;
    if (s[127]) t = t ^ 128'h87;
    return t ^ d;
  endfunction

  task automatic model_zero();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = '0;
      m_sig[i]   = seed[i];
      m_cnt[i]   = 0;
      m_done[i]  = 1'b0;
      m_err[i]   = 1'b0;
    end
  endtask

  task automatic model_step(input bit iv, input logic [127:0] o, input bit clr);
    bit m;
    longint unsigned t;
    m = (exp_q.size() > 0) && (exp_q[0] == edge_n);
    if (m) void'(exp_q.pop_front());
    if (clr) begin
      model_zero();
    end else begin
      for (int i = 0; i < 2; i++) begin
        t = (i == 0) ? longint'(tgt) : longint'(tgt[1:0]);
        m_valid[i] = 1'b0;
        if (m && m_done[i]) begin
          m_err[i] = 1'b1;
        end else if (m) begin
          m_valid[i] = 1'b1;
          m_data[i]  = o;
          m_sig[i]   = misr(m_sig[i], o);
          if (m_cnt[i] < max_cnt[i]) m_cnt[i] = m_cnt[i] + 1;
          if (t != 0 && m_cnt[i] == t) m_done[i] = 1'b1;
        end
      end
      if (iv) exp_q.push_back(edge_n + L);
    end
    edge_n++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_valid", 128'(a_valid), 128'(m_valid[0]));
      chk("a_data",  a_data,        m_data[0]);
      chk("a_cnt",   128'(a_cnt),   128'(m_cnt[0]));
      chk("a_sig",   a_sig,         m_sig[0]);
      chk("a_done",  128'(a_done),  128'(m_done[0]));
      chk("a_err",   128'(a_err),   128'(m_err[0]));
      chk("b_valid", 128'(b_valid), 128'(m_valid[1]));
      chk("b_data",  b_data,        m_data[1]);
      chk("b_cnt",   128'(b_cnt),   128'(m_cnt[1]));
      chk("b_sig",   b_sig,         m_sig[1]);
      chk("b_done",  128'(b_done),  128'(m_done[1]));
      chk("b_err",   128'(b_err),   128'(m_err[1]));
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick(input bit iv, input logic [127:0] o, input bit clr);
    in_valid = iv;
    out_bus  = o;
    clear    = clr;
    @(posedge clk);
    model_step(iv, o, clr);
    #2;
  endtask

  task automatic idle(input int n, input logic [127:0] o);
    for (int k = 0; k < n; k++) tick(1'b0, o, 1'b0);
  endtask

  task automatic idle_rand(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, rnd128(), 1'b0);
  endtask

  task automatic pulse_rst();
    rst      = 1'b1;
    in_valid = 1'b0;
    clear    = 1'b0;
    model_zero();
    @(posedge clk);
    edge_n++;
    #2;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_zero();
    @(posedge clk);
    edge_n++;
    #2;
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset values.
    chk("rst_cnt", 128'(a_cnt), 128'd0);
    chk("rst_sig_b", b_sig, 128'h8000_0000_0000_0000_0000_0000_0000_0000);

    // Single launch, out = 1 throughout.
    tgt = 32'd0;
    tick(1'b1, 128'h1, 1'b0);
    idle(L - 1, 128'h1);
    chk("single_pre_valid", 128'(a_valid), 128'd0);
    idle(1, 128'h1);
    chk("single_valid", 128'(a_valid), 128'd1);
    chk("single_data", a_data, 128'h1);
    chk("single_sig", a_sig, 128'h1);
    chk("single_cnt", 128'(a_cnt), 128'd1);
    idle(1, 128'h1);
    chk("single_post_valid", 128'(a_valid), 128'd0);

    // Two back-to-back launches.
    tick(1'b0, 128'h1, 1'b1);
    tick(1'b1, 128'h1, 1'b0);
    tick(1'b1, 128'h1, 1'b0);
    idle(L + 3, 128'h1);
    chk("pair_sig", a_sig, 128'h3);
    chk("pair_cnt", 128'(a_cnt), 128'd2);

    // Target of 3 with 5 launches.
    tick(1'b0, 128'h0, 1'b1);
    tgt = 32'd3;
    for (int k = 0; k < 5; k++) tick(1'b1, rnd128(), 1'b0);
    idle_rand(L + 4);
    chk("tgt_cnt", 128'(a_cnt), 128'd3);
    chk("tgt_done", 128'(a_done), 128'd1);
    chk("tgt_err", 128'(a_err), 128'd1);

    // Seed with top bit set, one capture of zero.
    tgt = 32'd0;
    tick(1'b0, 128'h0, 1'b1);
    tick(1'b1, 128'h0, 1'b0);
    idle(L + 1, 128'h0);
    chk("seed_sig_b", b_sig, 128'h87);
    chk("seed_cnt_b", 128'(b_cnt), 128'd1);

    // Reset 10 cycles into a 5-vector burst.
    tick(1'b0, 128'h0, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, rnd128(), 1'b0);
    idle_rand(5);
    pulse_rst();
    idle_rand(L + 10);
    chk("rstburst_cnt", 128'(a_cnt), 128'd0);
    chk("rstburst_data", a_data, 128'h0);

    // Clear coinciding with the match edge.
    tick(1'b1, 128'h5, 1'b0);
    idle(L - 1, 128'h5);
    tick(1'b0, 128'h5, 1'b1);
    chk("clrmatch_valid", 128'(a_valid), 128'd0);
    chk("clrmatch_cnt", 128'(a_cnt), 128'd0);
    chk("clrmatch_sig", a_sig, 128'h0);
    idle(3, 128'h5);

    // Lowering the target below the count does not set done.
    tgt = 32'd5;
    for (int k = 0; k < 3; k++) tick(1'b1, rnd128(), 1'b0);
    idle_rand(L + 2);
    tgt = 32'd2;
    for (int k = 0; k < 3; k++) tick(1'b1, rnd128(), 1'b0);
    idle_rand(L + 2);
    chk("lower_cnt", 128'(a_cnt), 128'd6);
    chk("lower_done", 128'(a_done), 128'd0);

    // Mixed traffic, unbounded target, occasional clears.
    tgt = 32'd0;
    tick(1'b0, 128'h0, 1'b1);
    for (int k = 0; k < 150; k++)
      tick(1'($urandom_range(0, 1)), rnd128(), ($urandom_range(0, 40) == 0));
    idle_rand(L + 2);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
